// File: rtl/bank_act_sched.sv
// Per-bank ACT/PRE scheduler with open-row table, tRAS/tRRD/tRP/tRCD tracking.
// Optional tFAW window enabled by defining BANK_ACT_TFAW_EN.
module bank_act_sched #(
    parameter int NUM_BANKS = 16,
    parameter int RA_WIDTH  = 15,
    parameter int CNT_W     = 8,
    parameter int T_RCD     = 11,
    parameter int T_RP      = 11,
    parameter int T_RAS     = 28,
    parameter int T_RTP     = 6,
    parameter int T_RRD     = 4,
`ifdef BANK_ACT_TFAW_EN
    parameter int T_FAW     = 30,
`endif
    localparam int BA_W     = $clog2(NUM_BANKS)
) (
    input  logic                clock_t,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [BA_W-1:0]     req_bank,
    input  logic [RA_WIDTH-1:0] req_row,
    input  logic                req_rw,
    input  logic [CNT_W-1:0]    wr_delay,
    input  logic                cas_idle,
    input  logic                cas_rw,
    input  logic                flush,
    output logic                act_valid,
    output logic [BA_W-1:0]     act_bank,
    output logic [RA_WIDTH-1:0] act_row,
    output logic                pre_valid,
    output logic [BA_W-1:0]     pre_bank,
    output logic                cas_go,
    output logic                cas_go_rw,
    output logic                act_idle,
    output logic [3:0]          dbg_state
);
    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready never depends on req_valid, and the request is held in req_*_q afterwards.

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LOOKUP   = 4'd1,
        S_PRE_DATA = 4'd2,
        S_PRE_WAIT = 4'd3,
        S_PRE_CMD  = 4'd4,
        S_TRP      = 4'd5,
        S_RRD      = 4'd6,
        S_ACT      = 4'd7,
        S_TRCD     = 4'd8,
        S_CAS      = 4'd9
    } state_t;

    localparam int WW = CNT_W + 2;
    localparam logic [WW-1:0]    T_RCD_W = WW'(T_RCD);
    localparam logic [WW-1:0]    T_RP_W  = WW'(T_RP);
    localparam logic [WW-1:0]    T_RTP_W = WW'(T_RTP);
    localparam logic [WW-1:0]    T_RRD_W = WW'(T_RRD);
    localparam logic [CNT_W-1:0] T_RAS_C = CNT_W'(T_RAS);
    localparam logic [CNT_W-1:0] T_RRD_C = CNT_W'(T_RRD);

    state_t                state_q, state_d;
    logic [BA_W-1:0]       req_bank_q, req_bank_d;
    logic [RA_WIDTH-1:0]   req_row_q, req_row_d;
    logic                  req_rw_q, req_rw_d;
    logic                  rw_smp_q, rw_smp_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic [CNT_W-1:0]      rrd_q, rrd_d;
    logic [NUM_BANKS-1:0]  open_q, open_d;
    logic [RA_WIDTH-1:0]   row_q [NUM_BANKS];
    logic [RA_WIDTH-1:0]   row_d [NUM_BANKS];
    logic [CNT_W-1:0]      tras_q [NUM_BANKS];
    logic [CNT_W-1:0]      tras_d [NUM_BANKS];

    logic [WW-1:0] wait_inc, wait_sat, pre_need;
    logic          faw_ok, act_ok;

    assign wait_inc = wait_q + WW'(1);
    assign wait_sat = (&wait_q) ? wait_q : wait_inc;
    assign pre_need = rw_smp_q ? (WW'(wr_delay) + WW'(4) + T_RP_W) : T_RTP_W;
    // act_ok qualifies an ACT issued in the next cycle, hence the +1.
    assign act_ok   = ((WW'(rrd_q) + WW'(1)) >= T_RRD_W) && faw_ok;

`ifdef BANK_ACT_TFAW_EN
    logic [CNT_W-1:0] faw_age_q [4];
    logic [1:0]       faw_ptr_q;

    // Ring of the last four ACT ages; the slot at faw_ptr_q is the oldest.
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            faw_age_q <= '{default: CNT_W'(T_FAW)};
            faw_ptr_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (act_valid && (faw_ptr_q == 2'(i))) begin
                    faw_age_q[i] <= CNT_W'(1);
                end else if (WW'(faw_age_q[i]) < WW'(T_FAW)) begin
                    faw_age_q[i] <= faw_age_q[i] + CNT_W'(1);
                end
            end
            if (act_valid) begin
                faw_ptr_q <= faw_ptr_q + 2'd1;
            end
        end
    end

    assign faw_ok = (WW'(faw_age_q[faw_ptr_q]) + WW'(1)) >= WW'(T_FAW);
`else
    assign faw_ok = 1'b1;
`endif

    assign req_ready = (state_q == S_IDLE) && !flush && reset_n;
    assign act_valid = (state_q == S_ACT);
    assign act_bank  = act_valid ? req_bank_q : '0;
    assign act_row   = act_valid ? req_row_q : '0;
    assign pre_valid = (state_q == S_PRE_CMD);
    assign pre_bank  = pre_valid ? req_bank_q : '0;
    assign cas_go    = (state_q == S_CAS);
    assign cas_go_rw = cas_go ? req_rw_q : 1'b0;
    assign act_idle  = (state_q == S_IDLE);
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        req_bank_d = req_bank_q;
        req_row_d  = req_row_q;
        req_rw_d   = req_rw_q;
        rw_smp_d   = rw_smp_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    req_bank_d = req_bank;
                    req_row_d  = req_row;
                    req_rw_d   = req_rw;
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!open_q[req_bank_q]) begin
                    state_d = S_RRD;
                end else if (row_q[req_bank_q] == req_row_q) begin
                    state_d = S_CAS;
                end else begin
                    state_d = S_PRE_DATA;
                end
            end
            S_PRE_DATA: begin
                if (cas_idle) begin
                    rw_smp_d = cas_rw;
                    state_d  = S_PRE_WAIT;
                end
            end
            S_PRE_WAIT: begin
                if ((wait_inc >= pre_need) && (tras_q[req_bank_q] == '0)) begin
                    state_d = S_PRE_CMD;
                end else begin
                    wait_d = wait_sat;
                end
            end
            S_PRE_CMD: state_d = S_TRP;
            S_TRP: begin
                // Last tRP cycle doubles as the tRRD check so ACT lands at PRE + T_RP + 1.
                if (wait_inc >= T_RP_W) begin
                    state_d = act_ok ? S_ACT : S_RRD;
                end else begin
                    wait_d = wait_sat;
                end
            end
            S_RRD: begin
                if (act_ok) begin
                    state_d = S_ACT;
                end
            end
            S_ACT: state_d = S_TRCD;
            S_TRCD: begin
                if (wait_inc >= T_RCD_W) begin
                    state_d = S_CAS;
                end else begin
                    wait_d = wait_sat;
                end
            end
            S_CAS:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        for (int i = 0; i < NUM_BANKS; i++) begin
            tras_d[i] = (tras_q[i] != '0) ? (tras_q[i] - CNT_W'(1)) : '0;
        end
        rrd_d = rrd_q;
        if (act_valid) begin
            rrd_d = CNT_W'(1);
        end else if (rrd_q < T_RRD_C) begin
            rrd_d = rrd_q + CNT_W'(1);
        end
        if ((state_q == S_IDLE) && flush) begin
            open_d = '0;
        end
        if (state_q == S_PRE_CMD) begin
            open_d[req_bank_q] = 1'b0;
        end
        if (state_q == S_ACT) begin
            open_d[req_bank_q] = 1'b1;
            row_d[req_bank_q]  = req_row_q;
            tras_d[req_bank_q] = T_RAS_C;
        end
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            req_bank_q <= '0;
            req_row_q  <= '0;
            req_rw_q   <= 1'b0;
            rw_smp_q   <= 1'b0;
            wait_q     <= '0;
            rrd_q      <= T_RRD_C;
            open_q     <= '0;
            row_q      <= '{default: '0};
            tras_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            req_bank_q <= req_bank_d;
            req_row_q  <= req_row_d;
            req_rw_q   <= req_rw_d;
            rw_smp_q   <= rw_smp_d;
            wait_q     <= wait_d;
            rrd_q      <= rrd_d;
            open_q     <= open_d;
            row_q      <= row_d;
            tras_q     <= tras_d;
        end
    end

endmodule

// File: doc/bank_act_sched.md
BANK_ACT_SCHED -- requirements
Module: bank_act_sched

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 16, meaning bank count (bank group and bank address flattened); BA_W = clog2(NUM_BANKS).
REQ-002 SHALL have parameter RA_WIDTH, default 15, meaning row address width.
REQ-003 SHALL have parameter CNT_W, default 8, meaning width of every timing counter.
REQ-004 SHALL have parameters T_RCD, T_RP, T_RAS, T_RTP, T_RRD with defaults 11, 11, 28, 6, 4, in clock_t cycles.
REQ-005 SHALL have port clock_t  in  1  the single clock, all logic rising-edge.
REQ-006 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have ports req_valid in 1, req_ready out 1, req_bank in BA_W, req_row in RA_WIDTH, req_rw in 1 (1=write), forming the access request handshake.
REQ-008 SHALL have ports wr_delay in CNT_W (WL), cas_idle in 1, cas_rw in 1 (last CAS type), flush in 1 (external PREA/refresh done).
REQ-009 SHALL have outputs act_valid 1, act_bank BA_W, act_row RA_WIDTH, pre_valid 1, pre_bank BA_W, cas_go 1, cas_go_rw 1, act_idle 1.

Function
REQ-010 SHALL keep per-bank open-row table: open flag plus row, and per-bank tRAS down-counter.
REQ-011 SHALL assert req_ready only in S_IDLE with flush low; transfer = req_valid && req_ready, captured into a request register.
REQ-012 SHALL use states S_IDLE, S_LOOKUP, S_PRE_DATA, S_PRE_WAIT, S_PRE_CMD, S_TRP, S_RRD, S_ACT, S_TRCD, S_CAS.
REQ-013 SHALL go S_IDLE -> S_LOOKUP on transfer; S_LOOKUP classifies: hit (open, row equal) -> S_CAS; empty (not open) -> S_RRD; miss (open, row differs) -> S_PRE_DATA.
REQ-014 SHALL pulse cas_go with cas_go_rw = captured req_rw for exactly one cycle in S_CAS, then return to S_IDLE; hit latency transfer-to-cas_go = 2 cycles.
REQ-015 SHALL hold S_PRE_DATA until cas_idle=1, sampling cas_rw at that cycle.
REQ-016 SHALL hold S_PRE_WAIT until both: extra-wait count reached (T_RTP if sampled read, wr_delay+4+tWR if write, tWR = T_RP) and that bank's tRAS counter = 0.
REQ-017 SHALL pulse pre_valid with pre_bank one cycle in S_PRE_CMD, clear that bank's open flag, then wait T_RP cycles in S_TRP before S_RRD.
REQ-018 SHALL hold S_RRD until at least T_RRD cycles since the previous act_valid (counter saturates at T_RRD; satisfied after reset).
REQ-019 SHALL pulse act_valid with act_bank/act_row one cycle in S_ACT, set table entry open with new row, load bank tRAS counter with T_RAS.
REQ-020 SHALL wait T_RCD cycles in S_TRCD after act_valid, then S_CAS.
REQ-021 SHALL never assert more than one of act_valid, pre_valid, cas_go in any cycle.
REQ-022 SHALL decrement every nonzero tRAS counter each cycle, saturating at 0.
REQ-023 SHALL, on flush=1 in S_IDLE, clear all open flags in that cycle; flush outside S_IDLE is held off until S_IDLE.
REQ-024 SHALL assert act_idle=1 exactly when state = S_IDLE.
REQ-025 SHALL treat T_RTP/T_RCD/T_RP of 0 as a single-cycle pass through the wait state.

Reset
REQ-026 SHALL, on reset_n low at any time including mid-sequence, force S_IDLE, all open flags 0, tRAS counters 0, tRRD satisfied, act_valid=pre_valid=cas_go=0, act_bank/act_row/pre_bank/cas_go_rw = 0, req_ready=0 while reset held, act_idle=1.
REQ-027 SHALL assert req_ready in the first cycle after reset_n deasserts.

Configuration
REQ-028 SHALL support macro BANK_ACT_TFAW_EN: when defined, a 4-entry ACT timestamp window plus parameter T_FAW (default 30) blocks S_RRD exit until fewer than 4 act_valid occurred in the last T_FAW cycles; when undefined, only T_RRD gates ACT and no tFAW logic exists.

Verification
REQ-029 SHALL cover: reset, req bank 3 row 0x10 read -> act_valid bank 3 row 0x10, cas_go exactly T_RCD+1 cycles later.
REQ-030 SHALL cover: repeat bank 3 row 0x10 write -> no act_valid/pre_valid, cas_go 2 cycles after transfer, cas_go_rw=1.
REQ-031 SHALL cover: bank 3 row 0x22 after write, wr_delay=9, cas_idle already 1 -> pre_valid bank 3 no earlier than 9+4+T_RP cycles and tRAS expiry, act_valid row 0x22 T_RP+1 cycles after pre_valid.
REQ-032 SHALL cover: back-to-back empty banks 0,1 -> act_valid spacing >= T_RRD; with BANK_ACT_TFAW_EN, fifth ACT in 5 banks spaced >= T_FAW from first.
REQ-033 SHALL cover: reset_n pulsed low during S_TRP -> outputs at reset values, next request to same bank classified empty (act without pre).
REQ-034 SHALL cover: flush in S_IDLE with banks 3,5 open -> subsequent requests to 3 and 5 issue act_valid without pre_valid.
